// File: rtl/eth_seq_pkg.sv
`default_nettype none
// eth_seq_pkg: shared state encodings and helpers for the MAC buffer sequencer.
package eth_seq_pkg;

   typedef enum logic [2:0] {
      T_IDLE, T_FILL, T_DROP, T_SIZE, T_SEND, T_BUSY_LO, T_BUSY_HI
   } tx_state_e;

   typedef enum logic [2:0] {
      R_IDLE, R_READ, R_OUT, R_CLEAR, R_WAIT
   } rx_state_e;

   localparam int word_bytes_lp = 8;

   function automatic logic [7:0] keep_from_remaining(input logic [15:0] r);
      logic [7:0] k;
      if (r >= 16'(word_bytes_lp)) k = 8'hFF;
      else                         k = (8'd1 << r[2:0]) - 8'd1;
      return k;
   endfunction

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/eth_seq_sat_counter.sv
`default_nettype none
// eth_seq_sat_counter: event counter that sticks at all-ones instead of wrapping.
module eth_seq_sat_counter #(
   parameter int width_p = 16
)(
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               inc_i,
   output logic [width_p-1:0] count_o
);

   always_ff @(posedge clk_i) begin
      if (reset_i)                      count_o <= '0;
      else if (inc_i && count_o != '1)  count_o <= count_o + width_p'(1);
   end

endmodule
`default_nettype wire

// File: rtl/eth_buffer_sequencer.sv
`default_nettype none
// eth_buffer_sequencer: client streams <-> 1G MAC register-style packet buffers.
// Statistics counters are built only when ETH_SEQ_STATS_EN is defined.
module eth_buffer_sequencer
   import eth_seq_pkg::*;
#(
   parameter  int buf_size_p    = 2048,
   parameter  int data_width_p  = 64,
   localparam int addr_width_lp = $clog2(buf_size_p),
   localparam int size_width_lp = $clog2(buf_size_p) + 1
)(
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [data_width_p-1:0]  tx_data_i,
   input  logic [7:0]               tx_keep_i,
   input  logic                     tx_last_i,
   input  logic                     tx_v_i,
   output logic                     tx_ready_o,
   input  logic                     mac_tx_ready_i,
   output logic                     mac_send_o,
   output logic                     mac_tx_size_v_o,
   output logic [size_width_lp-1:0] mac_tx_size_o,
   output logic [addr_width_lp-1:0] buf_write_addr_o,
   output logic [1:0]               buf_write_op_size_o,
   output logic [data_width_p-1:0]  buf_write_data_o,
   output logic                     buf_write_v_o,
   input  logic                     mac_rx_ready_i,
   input  logic [15:0]              mac_rx_size_i,
   output logic [addr_width_lp-1:0] buf_read_addr_o,
   output logic                     buf_read_v_o,
   input  logic [data_width_p-1:0]  buf_read_data_i,
   output logic                     mac_clear_buffer_o,
   output logic [data_width_p-1:0]  rx_data_o,
   output logic [7:0]               rx_keep_o,
   output logic                     rx_last_o,
   output logic                     rx_v_o,
   input  logic                     rx_ready_i,
   output logic                     tx_overflow_o,
   output logic [15:0]              stat_tx_sent_o,
   output logic [15:0]              stat_tx_drop_o,
   output logic [15:0]              stat_rx_frames_o
);

   localparam int idx_width_lp = addr_width_lp - 3;

   tx_state_e                tx_state, tx_state_n;
   logic [size_width_lp-1:0] tx_count, tx_count_n;
   logic [idx_width_lp:0]    tx_index, tx_index_n;
   logic                     tx_ovf_n;
   logic [size_width_lp-1:0] fill_sum;
   logic                     fill_over;

   rx_state_e                rx_state, rx_state_n;
   logic [15:0]              rx_rem, rx_rem_n;
   logic [idx_width_lp-1:0]  rx_index, rx_index_n;
   logic                     rx_fresh, rx_fresh_n;
   logic [data_width_p-1:0]  rx_hold, rx_hold_n;

   assign buf_write_op_size_o = 2'b11;

   // The extra index bit catches a word count past the buffer even when keeps are sparse.
   assign fill_sum  = tx_count + size_width_lp'(popcount8(tx_keep_i));
   assign fill_over = (fill_sum > size_width_lp'(buf_size_p)) || tx_index[idx_width_lp];

   always_comb begin
      tx_state_n       = tx_state;
      tx_count_n       = tx_count;
      tx_index_n       = tx_index;
      tx_ovf_n         = tx_overflow_o;
      tx_ready_o       = 1'b0;
      buf_write_v_o    = 1'b0;
      buf_write_addr_o = '0;
      buf_write_data_o = '0;
      mac_tx_size_v_o  = 1'b0;
      mac_tx_size_o    = '0;
      mac_send_o       = 1'b0;
      if (!reset_i) begin
         case (tx_state)
            T_IDLE: begin
               tx_ready_o = mac_tx_ready_i;
               if (tx_v_i && mac_tx_ready_i) begin
                  buf_write_v_o    = 1'b1;
                  buf_write_data_o = tx_data_i;
                  tx_count_n       = size_width_lp'(popcount8(tx_keep_i));
                  tx_index_n       = (idx_width_lp+1)'(1);
                  tx_state_n       = tx_last_i ? T_SIZE : T_FILL;
               end
            end
            T_FILL: begin
               tx_ready_o = 1'b1;
               if (tx_v_i) begin
                  if (fill_over) begin
                     tx_ovf_n   = 1'b1;
                     tx_state_n = tx_last_i ? T_IDLE : T_DROP;
                  end else begin
                     buf_write_v_o    = 1'b1;
                     buf_write_addr_o = {tx_index[idx_width_lp-1:0], 3'b000};
                     buf_write_data_o = tx_data_i;
                     tx_count_n       = fill_sum;
                     tx_index_n       = tx_index + (idx_width_lp+1)'(1);
                     if (tx_last_i) tx_state_n = (fill_sum == '0) ? T_IDLE : T_SIZE;
                  end
               end
            end
            T_DROP: begin
               tx_ready_o = 1'b1;
               if (tx_v_i && tx_last_i) tx_state_n = T_IDLE;
            end
            T_SIZE: begin
               mac_tx_size_v_o = 1'b1;
               mac_tx_size_o   = tx_count;
               tx_state_n      = T_SEND;
            end
            T_SEND: begin
               mac_send_o = 1'b1;
               tx_state_n = T_BUSY_LO;
            end
            T_BUSY_LO: if (!mac_tx_ready_i) tx_state_n = T_BUSY_HI;
            T_BUSY_HI: if (mac_tx_ready_i)  tx_state_n = T_IDLE;
            default:   tx_state_n = T_IDLE;
         endcase
      end
   end

   always_comb begin
      rx_state_n         = rx_state;
      rx_rem_n           = rx_rem;
      rx_index_n         = rx_index;
      rx_fresh_n         = 1'b0;
      rx_hold_n          = rx_hold;
      buf_read_v_o       = 1'b0;
      buf_read_addr_o    = '0;
      mac_clear_buffer_o = 1'b0;
      rx_v_o             = 1'b0;
      rx_data_o          = '0;
      rx_keep_o          = '0;
      rx_last_o          = 1'b0;
      if (!reset_i) begin
         case (rx_state)
            R_IDLE: begin
               if (mac_rx_ready_i) begin
                  // rx_rem == 0 in R_CLEAR marks a discarded frame.
                  if (mac_rx_size_i == '0 || mac_rx_size_i > 16'(buf_size_p)) begin
                     rx_rem_n   = '0;
                     rx_state_n = R_CLEAR;
                  end else begin
                     rx_rem_n   = mac_rx_size_i;
                     rx_index_n = '0;
                     rx_state_n = R_READ;
                  end
               end
            end
            R_READ: begin
               buf_read_v_o    = 1'b1;
               buf_read_addr_o = {rx_index, 3'b000};
               rx_fresh_n      = 1'b1;
               rx_state_n      = R_OUT;
            end
            R_OUT: begin
               // First cycle forwards the buffer data; later cycles replay the held copy.
               rx_v_o    = 1'b1;
               rx_data_o = rx_fresh ? buf_read_data_i : rx_hold;
               rx_keep_o = keep_from_remaining(rx_rem);
               rx_last_o = (rx_rem <= 16'(word_bytes_lp));
               if (rx_fresh) rx_hold_n = buf_read_data_i;
               if (rx_ready_i) begin
                  if (rx_last_o) begin
                     rx_state_n = R_CLEAR;
                  end else begin
                     rx_index_n = rx_index + idx_width_lp'(1);
                     rx_rem_n   = rx_rem - 16'(word_bytes_lp);
                     rx_state_n = R_READ;
                  end
               end
            end
            R_CLEAR: begin
               mac_clear_buffer_o = 1'b1;
               rx_state_n         = R_WAIT;
            end
            R_WAIT:  if (!mac_rx_ready_i) rx_state_n = R_IDLE;
            default: rx_state_n = R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tx_state      <= T_IDLE;
         tx_count      <= '0;
         tx_index      <= '0;
         tx_overflow_o <= 1'b0;
         rx_state      <= R_IDLE;
         rx_rem        <= '0;
         rx_index      <= '0;
         rx_fresh      <= 1'b0;
         rx_hold       <= '0;
      end else begin
         tx_state      <= tx_state_n;
         tx_count      <= tx_count_n;
         tx_index      <= tx_index_n;
         tx_overflow_o <= tx_ovf_n;
         rx_state      <= rx_state_n;
         rx_rem        <= rx_rem_n;
         rx_index      <= rx_index_n;
         rx_fresh      <= rx_fresh_n;
         rx_hold       <= rx_hold_n;
      end
   end

`ifdef ETH_SEQ_STATS_EN
   logic tx_drop_evt;
   logic rx_frame_evt;

   assign tx_drop_evt = !reset_i && tx_v_i && tx_last_i &&
                        ((tx_state == T_DROP) ||
                         (tx_state == T_FILL && (fill_over || fill_sum == '0)));
   assign rx_frame_evt = mac_clear_buffer_o && (rx_rem != '0);

   eth_seq_sat_counter #(.width_p(16)) u_stat_tx_sent (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (mac_send_o),
      .count_o (stat_tx_sent_o)
   );

   eth_seq_sat_counter #(.width_p(16)) u_stat_tx_drop (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (tx_drop_evt),
      .count_o (stat_tx_drop_o)
   );

   eth_seq_sat_counter #(.width_p(16)) u_stat_rx_frames (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (rx_frame_evt),
      .count_o (stat_rx_frames_o)
   );
`else
   assign stat_tx_sent_o   = '0;
   assign stat_tx_drop_o   = '0;
   assign stat_rx_frames_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_buffer_sequencer.sv
`default_nettype none
// tb_eth_buffer_sequencer: directed scoreboard bench for eth_buffer_sequencer.
module tb_eth_buffer_sequencer;

   localparam int BUF = 2048;
`ifdef ETH_SEQ_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_i;
   logic [63:0] tx_data_i;
   logic [7:0]  tx_keep_i;
   logic        tx_last_i, tx_v_i, tx_ready_o;
   logic        mac_tx_ready_i, mac_send_o, mac_tx_size_v_o;
   logic [11:0] mac_tx_size_o;
   logic [10:0] buf_write_addr_o;
   logic [1:0]  buf_write_op_size_o;
   logic [63:0] buf_write_data_o;
   logic        buf_write_v_o;
   logic        mac_rx_ready_i;
   logic [15:0] mac_rx_size_i;
   logic [10:0] buf_read_addr_o;
   logic        buf_read_v_o;
   logic [63:0] buf_read_data_i;
   logic        mac_clear_buffer_o;
   logic [63:0] rx_data_o;
   logic [7:0]  rx_keep_o;
   logic        rx_last_o, rx_v_o, rx_ready_i;
   logic        tx_overflow_o;
   logic [15:0] stat_tx_sent_o, stat_tx_drop_o, stat_rx_frames_o;

   always #5 clk = ~clk;

   eth_buffer_sequencer #(.buf_size_p(BUF), .data_width_p(64)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .tx_data_i(tx_data_i), .tx_keep_i(tx_keep_i), .tx_last_i(tx_last_i),
      .tx_v_i(tx_v_i), .tx_ready_o(tx_ready_o),
      .mac_tx_ready_i(mac_tx_ready_i), .mac_send_o(mac_send_o),
      .mac_tx_size_v_o(mac_tx_size_v_o), .mac_tx_size_o(mac_tx_size_o),
      .buf_write_addr_o(buf_write_addr_o), .buf_write_op_size_o(buf_write_op_size_o),
      .buf_write_data_o(buf_write_data_o), .buf_write_v_o(buf_write_v_o),
      .mac_rx_ready_i(mac_rx_ready_i), .mac_rx_size_i(mac_rx_size_i),
      .buf_read_addr_o(buf_read_addr_o), .buf_read_v_o(buf_read_v_o),
      .buf_read_data_i(buf_read_data_i), .mac_clear_buffer_o(mac_clear_buffer_o),
      .rx_data_o(rx_data_o), .rx_keep_o(rx_keep_o), .rx_last_o(rx_last_o),
      .rx_v_o(rx_v_o), .rx_ready_i(rx_ready_i),
      .tx_overflow_o(tx_overflow_o),
      .stat_tx_sent_o(stat_tx_sent_o), .stat_tx_drop_o(stat_tx_drop_o),
      .stat_rx_frames_o(stat_rx_frames_o)
   );

   // RX buffer model: one-cycle read latency.
   logic [63:0] rx_mem [0:255];
   always @(posedge clk) if (buf_read_v_o) buf_read_data_i <= rx_mem[buf_read_addr_o[10:3]];

   int checks = 0;
   int errors = 0;
   int n_send = 0, n_sizev = 0, n_clear = 0, n_read = 0, n_rxv = 0;
   logic [7:0] last_keep_seen = 8'h00;

   int          exp_wa [$];
   logic [63:0] exp_wd [$];
   int          exp_size [$];
   logic [63:0] exp_rd [$];
   logic [7:0]  exp_rk [$];
   logic        exp_rl [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (buf_write_v_o) begin
         check("wr_pending", exp_wa.size() != 0, 1'b1);
         check("wr_op_size", buf_write_op_size_o, 2'b11);
         if (exp_wa.size() != 0) begin
            check("wr_addr", buf_write_addr_o, exp_wa.pop_front());
            check("wr_data", buf_write_data_o, exp_wd.pop_front());
         end
      end
      if (mac_tx_size_v_o) begin
         n_sizev++;
         check("size_pending", exp_size.size() != 0, 1'b1);
         if (exp_size.size() != 0) check("tx_size", mac_tx_size_o, exp_size.pop_front());
      end
      if (mac_send_o)         n_send++;
      if (mac_clear_buffer_o) n_clear++;
      if (buf_read_v_o)       n_read++;
      if (rx_v_o) begin
         n_rxv++;
         if (rx_ready_i) begin
            check("rx_pending", exp_rd.size() != 0, 1'b1);
            if (exp_rd.size() != 0) begin
               check("rx_data", rx_data_o, exp_rd.pop_front());
               check("rx_keep", rx_keep_o, exp_rk.pop_front());
               check("rx_last", rx_last_o, exp_rl.pop_front());
            end
            if (rx_last_o) last_keep_seen = rx_keep_o;
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx"}, {tx_ready_o, mac_send_o, mac_tx_size_v_o, mac_tx_size_o,
                           buf_write_addr_o, buf_write_v_o, tx_overflow_o,
                           buf_write_op_size_o}, 64'h3);
      check({tag, "_wdata"}, buf_write_data_o, 64'h0);
      check({tag, "_rx"}, {buf_read_addr_o, buf_read_v_o, mac_clear_buffer_o,
                           rx_keep_o, rx_last_o, rx_v_o}, 64'h0);
      check({tag, "_rdata"}, rx_data_o, 64'h0);
      check({tag, "_stats"}, {stat_tx_sent_o, stat_tx_drop_o, stat_rx_frames_o}, 64'h0);
   endtask

   task automatic tx_packet(input int nbytes);
      int nwords, cnt, b, guard;
      bit ovf;
      logic [63:0] d;
      nwords = (nbytes + 7) / 8;
      cnt = 0;
      ovf = 1'b0;
      for (int w = 0; w < nwords; w++) begin
         b = (nbytes - w * 8 >= 8) ? 8 : nbytes - w * 8;
         d = {$urandom, $urandom};
         step();
         tx_data_i = d;
         tx_keep_i = 8'((9'd1 << b) - 9'd1);
         tx_last_i = (w == nwords - 1);
         tx_v_i    = 1'b1;
         if (!ovf) begin
            if (cnt + b > BUF) ovf = 1'b1;
            else begin
               cnt += b;
               exp_wa.push_back(w * 8);
               exp_wd.push_back(d);
               if (w == nwords - 1) exp_size.push_back(cnt);
            end
         end
         guard = 0;
         do begin
            @(negedge clk);
            guard++;
         end while (!tx_ready_o && guard < 50);
         check("tx_accept", tx_ready_o, 1'b1);
      end
      step();
      tx_v_i    = 1'b0;
      tx_last_i = 1'b0;
   endtask

   // Waits for the send pulse, then walks the MAC ready low/high handshake.
   task automatic tx_finish(input int sends_expected);
      int guard;
      guard = 0;
      while (n_send < sends_expected && guard < 20) begin
         step();
         guard++;
      end
      check("send_seen", n_send, sends_expected);
      repeat (3) begin
         @(negedge clk);
         check("busy_ready_hold", tx_ready_o, 1'b0);
      end
      step();
      mac_tx_ready_i = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("busy_ready_lo", tx_ready_o, 1'b0);
      end
      step();
      mac_tx_ready_i = 1'b1;
      @(negedge clk);
      check("busy_hi_wait", tx_ready_o, 1'b0);
      @(negedge clk);
      check("tx_ready_back", tx_ready_o, 1'b1);
      check("send_once", n_send, sends_expected);
      check("tx_wr_drained", exp_wa.size(), 0);
   endtask

   task automatic rx_frame(input int nbytes, input bit toggle);
      int words, c0, r0, v0, guard, r;
      bit valid;
      c0 = n_clear;
      r0 = n_read;
      v0 = n_rxv;
      words = (nbytes + 7) / 8;
      valid = (nbytes > 0) && (nbytes <= BUF);
      if (valid) begin
         for (int i = 0; i < words; i++) begin
            rx_mem[i] = {$urandom, $urandom};
            r = nbytes - i * 8;
            exp_rd.push_back(rx_mem[i]);
            exp_rk.push_back(r >= 8 ? 8'hFF : 8'((9'd1 << r) - 9'd1));
            exp_rl.push_back(i == words - 1);
         end
      end
      step();
      mac_rx_size_i  = 16'(nbytes);
      mac_rx_ready_i = 1'b1;
      rx_ready_i     = 1'b1;
      guard = 0;
      while (n_clear == c0 && guard < 400) begin
         step();
         if (toggle) rx_ready_i = ~rx_ready_i;
         guard++;
      end
      check("rx_clear", n_clear - c0, 1);
      repeat (10) step();
      check("rx_clear_once", n_clear - c0, 1);
      check("rx_reads", n_read - r0, valid ? words : 0);
      check("rx_drained", exp_rd.size(), 0);
      if (!valid) check("rx_no_valid", n_rxv - v0, 0);
      mac_rx_ready_i = 1'b0;
      rx_ready_i     = 1'b0;
      repeat (3) step();
   endtask

   initial begin
      int guard, s0, z0, c0;
      reset_i = 1'b1;
      tx_data_i = '0; tx_keep_i = '0; tx_last_i = 1'b0; tx_v_i = 1'b0;
      mac_tx_ready_i = 1'b0; mac_rx_ready_i = 1'b0; mac_rx_size_i = '0;
      rx_ready_i = 1'b0; buf_read_data_i = '0;
      repeat (2) step();
      @(negedge clk);
      check_reset_outputs("reset");
      step();
      reset_i = 1'b0;
      @(negedge clk);
      check_reset_outputs("post_reset");
      step();
      mac_tx_ready_i = 1'b1;

      tx_packet(64);
      tx_finish(1);
      tx_packet(61);
      tx_finish(2);
      check("ovf_clear_before", tx_overflow_o, 1'b0);

      tx_packet(2056);
      repeat (5) step();
      check("ovf_no_send", n_send, 2);
      check("ovf_sticky", tx_overflow_o, 1'b1);
      check("ovf_idle_ready", tx_ready_o, 1'b1);
      check("ovf_writes", exp_wa.size(), 0);
      check("ovf_no_size", exp_size.size(), 0);
      check("stat_tx_drop", stat_tx_drop_o, STATS ? 16'd1 : 16'd0);
      check("stat_tx_sent", stat_tx_sent_o, STATS ? 16'd2 : 16'd0);

      rx_frame(70, 1'b1);
      check("rx70_last_keep", last_keep_seen, 8'h3F);
      rx_frame(0, 1'b0);
      rx_frame(4000, 1'b0);
      check("stat_rx_frames", stat_rx_frames_o, STATS ? 16'd1 : 16'd0);

      // Reset in the middle of a TX fill.
      s0 = n_send;
      z0 = n_sizev;
      for (int w = 0; w < 2; w++) begin
         step();
         tx_data_i = {$urandom, $urandom};
         tx_keep_i = 8'hFF;
         tx_last_i = 1'b0;
         tx_v_i    = 1'b1;
         exp_wa.push_back(w * 8);
         exp_wd.push_back(tx_data_i);
         @(negedge clk);
      end
      step();
      tx_v_i = 1'b0;
      reset_i = 1'b1;
      mac_tx_ready_i = 1'b0;
      step();
      reset_i = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_fill");
      step();
      mac_tx_ready_i = 1'b1;
      repeat (10) step();
      check("rst_fill_no_send", n_send - s0, 0);
      check("rst_fill_no_size", n_sizev - z0, 0);
      check("rst_fill_writes", exp_wa.size(), 0);

      // Reset while an RX word is being presented.
      c0 = n_clear;
      rx_mem[0] = {$urandom, $urandom};
      rx_mem[1] = {$urandom, $urandom};
      step();
      rx_ready_i = 1'b0;
      mac_rx_size_i = 16'd16;
      mac_rx_ready_i = 1'b1;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!rx_v_o && guard < 20);
      check("rst_rout_reach", rx_v_o, 1'b1);
      step();
      reset_i = 1'b1;
      mac_rx_ready_i = 1'b0;
      mac_tx_ready_i = 1'b0;
      step();
      reset_i = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_rout");
      repeat (10) step();
      check("rst_rout_no_clear", n_clear - c0, 0);
      check("rst_rout_idle", rx_v_o, 1'b0);

      check("final_size_q", exp_size.size(), 0);
      check("final_rx_q", exp_rd.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
